pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage rv32imc pipeline. Decides each
//  cycle which pipeline registers hold, which take a bubble and which flush.
//  Covers load-use hazards the forwarding path cannot resolve, multi-cycle
//  MUL/DIV occupancy of EX, cache-miss freezes and EX-resolved redirects.
//  Sits beside the forwarding unit; drives enables of IF/ID, ID/EX, EX/MEM, MEM/WB.
// PARAMETERS
//  MUL_LAT     3   cycles a MUL occupies EX (>=1); stall cycles = MUL_LAT-1
//  DIV_LAT     33  cycles a DIV/REM occupies EX (>=1); stall cycles = DIV_LAT-1
//  PERF_W      32  width of each performance counter (PERF_CNT_EN only)
// PORTS
//  clk             in   1       core clock
//  rst_n           in   1       asynchronous, active-low reset
//  id_rs1_addr     in   5       rs1 of instruction in ID
//  id_rs2_addr     in   5       rs2 of instruction in ID
//  id_rs1_used     in   1       ID instruction reads rs1
//  id_rs2_used     in   1       ID instruction reads rs2
//  ex_rd_addr      in   5       rd of instruction in EX
//  ex_regf_we      in   1       EX instruction writes regfile
//  ex_is_load      in   1       EX instruction is a load
//  ex_mdu_op       in   1       EX holds valid MUL/DIV class op
//  ex_mdu_is_div   in   1       that op is DIV/DIVU/REM/REMU
//  ex_redirect     in   1       EX resolved taken branch/jump mispredict
//  imem_stall      in   1       I-cache miss pending
//  dmem_stall      in   1       D-cache miss pending
//  if_stall        out  1       hold PC and IF/ID
//  id_stall        out  1       hold ID/EX
//  ex_stall        out  1       hold EX/MEM
//  mem_stall       out  1       hold MEM/WB
//  id_flush        out  1       clear IF/ID valid
//  ex_bubble       out  1       load NOP into ID/EX
//  mem_bubble      out  1       load NOP into EX/MEM
//  mdu_busy        out  1       FSM in MDU_WAIT
// BEHAVIOUR
//  Reset: FSM=RUN, mdu_cnt=0, perf counters=0; all outputs 0 while rst_n low.
//  Priority each cycle: freeze > redirect > MDU wait > load-use > run.
//  freeze = imem_stall|dmem_stall: all four *_stall=1, all flush/bubble=0,
//   FSM and mdu_cnt hold; a redirect/MDU entry under freeze is deferred.
//  Redirect (RUN, no freeze): id_flush=1, ex_bubble=1, no stalls; load-use suppressed.
//  Load-use (RUN): ex_is_load & ex_regf_we & ex_rd_addr!=0 & ((id_rs1_used &
//   rs1==rd)|(id_rs2_used & rs2==rd)) -> if_stall=id_stall=1, ex_bubble=1,
//   one cycle, combinational; load advances, MEM forwarding resolves next cycle.
//  FSM RUN -> MDU_WAIT: ex_mdu_op & !freeze & LAT>1; mdu_cnt <= LAT-2
//   (LAT = DIV_LAT if ex_mdu_is_div else MUL_LAT). LAT==1: no entry, no stall.
//  MDU_WAIT: if/id/ex stall=1, mem_bubble=1, mem_stall=0; mdu_cnt decrements
//   per non-frozen cycle. Release when cnt==0 & !freeze: stalls=0 that cycle
//   (op leaves EX), next state RUN; no re-trigger on the same op.
//  mdu_cnt width $clog2(max(MUL_LAT,DIV_LAT)); never wraps below 0.
//  Hazards in ID during MDU_WAIT are evaluated only after release.
//  Async reset mid-MDU_WAIT: immediate return to RUN, cnt=0; op is lost
//   (pipeline reset discards it).
// CONFIGURATION
//  PIPELINE_HAZARD_PERF_CNT_EN defined: adds outputs perf_lu_cnt, perf_mdu_cnt,
//   perf_mem_cnt [PERF_W-1:0], incremented per load-use stall cycle, MDU_WAIT
//   stall cycle, freeze cycle; saturate at all-ones; cleared by reset.
//  Undefined: ports and counters absent; stall/flush behaviour identical.
// TESTING
//  lw x5 in EX (rd=5), ID add uses rs1=5 -> 1 cycle if/id_stall=1, ex_bubble=1, then 0.
//  lw rd=0, ID rs1=0 -> no stall; load rd=5, ID rs2=5 but rs2_used=0 -> no stall.
//  DIV in EX, DIV_LAT=33 -> 32 cycles if/id/ex_stall=1 + mem_bubble=1, release cycle 33, RUN.
//  MUL in EX with dmem_stall for 4 cycles mid-wait -> total stall 2+4=6, cnt held.
//  ex_redirect with concurrent load-use -> id_flush=1, ex_bubble=1, if_stall=0.
//  rst_n low at cnt=10 in MDU_WAIT -> outputs 0 immediately, FSM RUN after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage rv32imc pipeline.
// It handles these cases:
//   - load-use hazards that forwarding cannot resolve
//   - MUL/DIV occupancy of EX
//   - I/D cache-miss freezes
//   - redirects resolved in EX
// Optional feature macro: PIPELINE_HAZARD_PERF_CNT_EN adds saturating
// performance counters for load-use, MDU and freeze stall cycles.
module pipeline_hazard_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33
`ifdef PIPELINE_HAZARD_PERF_CNT_EN
   ,
   parameter int PERF_W  = 32
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_regf_we,
   input  logic       ex_is_load,
   input  logic       ex_mdu_op,
   input  logic       ex_mdu_is_div,
   input  logic       ex_redirect,
   input  logic       imem_stall,
   input  logic       dmem_stall,
   output logic       if_stall,
   output logic       id_stall,
   output logic       ex_stall,
   output logic       mem_stall,
   output logic       id_flush,
   output logic       ex_bubble,
   output logic       mem_bubble,
   output logic       mdu_busy
`ifdef PIPELINE_HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_lu_cnt,
   output logic [PERF_W-1:0] perf_mdu_cnt,
   output logic [PERF_W-1:0] perf_mem_cnt
`endif
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   // An op with latency 1 leaves EX in its first cycle and never enters the wait state.
   localparam bit MUL_MULTI = (MUL_LAT > 1);
   localparam bit DIV_MULTI = (DIV_LAT > 1);

   // The entry cycle is itself a stall cycle, so the counter is loaded with LAT-2.
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] mdu_cnt;
   logic [CNT_W-1:0] mdu_cnt_nxt;
   logic             freeze;
   logic             load_use;
   logic             mdu_enter;

   // Hazard detection terms shared by the sequencer.
   always_comb begin
      freeze    = imem_stall | dmem_stall;
      load_use  = ex_is_load & ex_regf_we & (ex_rd_addr != 5'd0) &
                  ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                   (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
      mdu_enter = ex_mdu_op & (ex_mdu_is_div ? DIV_MULTI : MUL_MULTI);
   end

   // FSM state and MDU countdown register; reset abandons any op in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         mdu_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mdu_cnt <= mdu_cnt_nxt;
      end
   end

   // Next state and per-cycle enables: freeze > redirect > MDU wait > load-use > run.
   always_comb begin
      state_nxt   = state;
      mdu_cnt_nxt = mdu_cnt;
      if_stall    = 1'b0;
      id_stall    = 1'b0;
      ex_stall    = 1'b0;
      mem_stall   = 1'b0;
      id_flush    = 1'b0;
      ex_bubble   = 1'b0;
      mem_bubble  = 1'b0;
      mdu_busy    = (state == ST_MDU_WAIT);

      if (freeze) begin
         // Whole pipe holds; FSM and counter hold, any redirect/MDU entry waits.
         if_stall  = 1'b1;
         id_stall  = 1'b1;
         ex_stall  = 1'b1;
         mem_stall = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (ex_redirect) begin
                  id_flush  = 1'b1;
                  ex_bubble = 1'b1;
               end else if (mdu_enter) begin
                  state_nxt   = ST_MDU_WAIT;
                  mdu_cnt_nxt = ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
                  if_stall    = 1'b1;
                  id_stall    = 1'b1;
                  ex_stall    = 1'b1;
                  mem_bubble  = 1'b1;
               end else if (load_use) begin
                  // Load moves on to MEM; forwarding from MEM covers the next cycle.
                  if_stall  = 1'b1;
                  id_stall  = 1'b1;
                  ex_bubble = 1'b1;
               end
            end
            ST_MDU_WAIT: begin
               if (mdu_cnt == '0) begin
                  // Release: the op leaves EX this cycle, so nothing holds.
                  state_nxt = ST_RUN;
               end else begin
                  mdu_cnt_nxt = mdu_cnt - 1'b1;
                  if_stall    = 1'b1;
                  id_stall    = 1'b1;
                  ex_stall    = 1'b1;
                  mem_bubble  = 1'b1;
               end
            end
            default: begin
               state_nxt   = ST_RUN;
               mdu_cnt_nxt = '0;
            end
         endcase
      end

      if (!rst_n) begin
         if_stall   = 1'b0;
         id_stall   = 1'b0;
         ex_stall   = 1'b0;
         mem_stall  = 1'b0;
         id_flush   = 1'b0;
         ex_bubble  = 1'b0;
         mem_bubble = 1'b0;
         mdu_busy   = 1'b0;
      end
   end

`ifdef PIPELINE_HAZARD_PERF_CNT_EN
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Event counters: only load-use sets if_stall with ex_bubble, only MDU stalls set
   // mem_bubble, and only a freeze sets mem_stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_lu_cnt  <= '0;
         perf_mdu_cnt <= '0;
         perf_mem_cnt <= '0;
      end else begin
         if (if_stall & ex_bubble) perf_lu_cnt  <= sat_inc(perf_lu_cnt);
         if (mem_bubble)           perf_mdu_cnt <= sat_inc(perf_mdu_cnt);
         if (mem_stall)            perf_mem_cnt <= sat_inc(perf_mem_cnt);
      end
   end
`endif

endmodule
